// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline results with buffered long-latency results
// into the single register-file write port, plus a pending-register scoreboard.
module wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_write,
    input  logic [4:0]  pipe_wrAddr,
    input  logic [31:0] pipe_wrData,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issueAddr,
    input  logic        lu_valid,
    input  logic [4:0]  lu_wrAddr,
    input  logic [31:0] lu_wrData,
    output logic        lu_ready,
    output logic        write,
    output logic [4:0]  wrAddr,
    output logic [31:0] wrData,
    input  logic [4:0]  rdAddrA,
    input  logic [4:0]  rdAddrB,
    output logic        stall,
    output logic [31:0] pending
);

    logic [4:0]  r_fifoAddr [0:1];
    logic [31:0] r_fifoData [0:1];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;

    logic        r_write;
    logic [4:0]  r_wrAddr;
    logic [31:0] r_wrData;
    logic [31:0] r_pending;

    logic        w_pipeReq;
    logic        w_empty;
    logic        w_ready;
    logic        w_deq;
    logic        w_enq;
    logic [4:0]  w_headAddr;
    logic [31:0] w_headData;
    logic [31:0] w_pendNext;
    logic        w_stallA;
    logic        w_stallB;

    assign w_pipeReq  = pipe_write & (|pipe_wrAddr);
    assign w_empty    = (r_count == 2'd0);
    assign w_ready    = (r_count != 2'd2);
    assign w_deq      = ~w_pipeReq & ~w_empty;
    // x0 results still handshake but are never buffered
    assign w_enq      = lu_valid & w_ready & (|lu_wrAddr);
    assign w_headAddr = r_fifoAddr[r_rptr];
    assign w_headData = r_fifoData[r_rptr];

    always_comb begin
        w_pendNext = r_pending;
        if (w_deq) begin
            w_pendNext[w_headAddr] = 1'b0;
        end
        // a newer issue to the same register outranks the retiring one
        if (lu_issue && (|lu_issueAddr)) begin
            w_pendNext[lu_issueAddr] = 1'b1;
        end
        w_pendNext[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifoAddr[0] <= '0;
            r_fifoAddr[1] <= '0;
            r_fifoData[0] <= '0;
            r_fifoData[1] <= '0;
            r_wptr        <= 1'b0;
            r_rptr        <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (w_enq) begin
                r_fifoAddr[r_wptr] <= lu_wrAddr;
                r_fifoData[r_wptr] <= lu_wrData;
                r_wptr             <= ~r_wptr;
            end
            if (w_deq) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write   <= 1'b0;
            r_wrAddr  <= '0;
            r_wrData  <= '0;
            r_pending <= '0;
        end else begin
            r_pending <= w_pendNext;
            if (w_pipeReq) begin
                r_write  <= 1'b1;
                r_wrAddr <= pipe_wrAddr;
                r_wrData <= pipe_wrData;
            end else if (!w_empty) begin
                r_write  <= 1'b1;
                r_wrAddr <= w_headAddr;
                r_wrData <= w_headData;
            end else begin
                r_write  <= 1'b0;
            end
        end
    end

    assign w_stallA = (|rdAddrA) & r_pending[rdAddrA];
    assign w_stallB = (|rdAddrB) & r_pending[rdAddrB];

    assign lu_ready = w_ready;
    assign write    = r_write;
    assign wrAddr   = r_wrAddr;
    assign wrData   = r_wrData;
    assign stall    = w_stallA | w_stallB;
    assign pending  = r_pending;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_write;
    logic [4:0]  pipe_wrAddr;
    logic [31:0] pipe_wrData;
    logic        lu_issue;
    logic [4:0]  lu_issueAddr;
    logic        lu_valid;
    logic [4:0]  lu_wrAddr;
    logic [31:0] lu_wrData;
    logic        lu_ready;
    logic        write;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic [4:0]  rdAddrA;
    logic [4:0]  rdAddrB;
    logic        stall;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;

    wb_arbiter dut (
        .clk(clk), .reset(reset),
        .pipe_write(pipe_write), .pipe_wrAddr(pipe_wrAddr), .pipe_wrData(pipe_wrData),
        .lu_issue(lu_issue), .lu_issueAddr(lu_issueAddr),
        .lu_valid(lu_valid), .lu_wrAddr(lu_wrAddr), .lu_wrData(lu_wrData),
        .lu_ready(lu_ready),
        .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
        .stall(stall), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pw;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        iss;
        logic [4:0]  ia;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        e_ready;
        logic        e_stall;
        logic        e_w;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic [31:0] e_pend;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    vec_t vt [0:19];

    ent_t        mq [$];
    logic [31:0] mp;
    logic        mw;
    logic [4:0]  ma;
    logic [31:0] md;

    function automatic vec_t mk(
        input logic pw, input logic [4:0] pa, input logic [31:0] pd,
        input logic iss, input logic [4:0] ia,
        input logic lv, input logic [4:0] la, input logic [31:0] ld,
        input logic [4:0] ra, input logic [4:0] rb,
        input logic er, input logic es,
        input logic ew, input logic [4:0] ea, input logic [31:0] ed,
        input logic [31:0] ep);
        vec_t v;
        v.pw = pw; v.pa = pa; v.pd = pd;
        v.iss = iss; v.ia = ia;
        v.lv = lv; v.la = la; v.ld = ld;
        v.ra = ra; v.rb = rb;
        v.e_ready = er; v.e_stall = es;
        v.e_w = ew; v.e_a = ea; v.e_d = ed; v.e_pend = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic iss, input logic [4:0] ia,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic [4:0] ra, input logic [4:0] rb);
        pipe_write = pw; pipe_wrAddr = pa; pipe_wrData = pd;
        lu_issue = iss; lu_issueAddr = ia;
        lu_valid = lv; lu_wrAddr = la; lu_wrData = ld;
        rdAddrA = ra; rdAddrB = rb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // directed table; state carries from row to row
        vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5, 32'hDEADBEEF, 32'h0);
        vt[1]  = mk(1, 0, 32'h1111,     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 32'hDEADBEEF, 32'h0);
        vt[2]  = mk(0, 0, 0,            1, 7, 0, 0, 0, 7, 0, 1, 0, 0, 5, 32'hDEADBEEF, 32'h80);
        vt[3]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 7, 0, 1, 1, 0, 5, 32'hDEADBEEF, 32'h80);
        vt[4]  = mk(0, 0, 0,            0, 0, 1, 7, 32'h12345678, 7, 0, 1, 1, 0, 5, 32'hDEADBEEF, 32'h80);
        vt[5]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 7, 0, 1, 1, 1, 7, 32'h12345678, 32'h0);
        vt[6]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 7, 0, 1, 0, 0, 7, 32'h12345678, 32'h0);
        vt[7]  = mk(1, 10, 32'hA0,      0, 0, 1, 1, 32'h1001, 0, 0, 1, 0, 1, 10, 32'hA0, 32'h0);
        vt[8]  = mk(1, 11, 32'hA1,      0, 0, 1, 2, 32'h1002, 0, 0, 1, 0, 1, 11, 32'hA1, 32'h0);
        vt[9]  = mk(1, 12, 32'hA2,      0, 0, 1, 3, 32'h1003, 0, 0, 0, 0, 1, 12, 32'hA2, 32'h0);
        vt[10] = mk(0, 0, 0,            0, 0, 1, 3, 32'h1003, 0, 0, 0, 0, 1, 1, 32'h1001, 32'h0);
        vt[11] = mk(0, 0, 0,            0, 0, 1, 3, 32'h1003, 0, 0, 1, 0, 1, 2, 32'h1002, 32'h0);
        vt[12] = mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 32'h1003, 32'h0);
        vt[13] = mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 32'h1003, 32'h0);
        vt[14] = mk(0, 0, 0,            1, 9, 0, 0, 0, 0, 0, 1, 0, 0, 3, 32'h1003, 32'h200);
        vt[15] = mk(0, 0, 0,            0, 0, 1, 9, 32'h99, 0, 0, 1, 0, 0, 3, 32'h1003, 32'h200);
        vt[16] = mk(0, 0, 0,            1, 9, 0, 0, 0, 9, 0, 1, 1, 1, 9, 32'h99, 32'h200);
        vt[17] = mk(0, 0, 0,            0, 0, 0, 0, 0, 9, 0, 1, 1, 0, 9, 32'h99, 32'h200);
        vt[18] = mk(0, 0, 0,            1, 0, 1, 0, 32'h55, 0, 0, 1, 0, 0, 9, 32'h99, 32'h200);
        vt[19] = mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 9, 1, 1, 0, 9, 32'h99, 32'h200);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_write", {31'b0, write}, 32'h0);
        chk("rst_wrAddr", {27'b0, wrAddr}, 32'h0);
        chk("rst_wrData", wrData, 32'h0);
        chk("rst_ready", {31'b0, lu_ready}, 32'h1);
        chk("rst_pending", pending, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].pw, vt[i].pa, vt[i].pd, vt[i].iss, vt[i].ia,
                  vt[i].lv, vt[i].la, vt[i].ld, vt[i].ra, vt[i].rb);
            #1;
            chk($sformatf("v%0d_ready", i), {31'b0, lu_ready}, {31'b0, vt[i].e_ready});
            chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vt[i].e_stall});
            tick();
            chk($sformatf("v%0d_write", i), {31'b0, write}, {31'b0, vt[i].e_w});
            chk($sformatf("v%0d_wrAddr", i), {27'b0, wrAddr}, {27'b0, vt[i].e_a});
            chk($sformatf("v%0d_wrData", i), wrData, vt[i].e_d);
            chk($sformatf("v%0d_pending", i), pending, vt[i].e_pend);
        end

        // fill FIFO behind a busy pipe, then reset mid-cycle
        drive(1, 4, 32'h44, 1, 6, 1, 6, 32'h66, 0, 0);
        tick();
        drive(1, 4, 32'h45, 0, 0, 1, 7, 32'h77, 0, 0);
        tick();
        drive(1, 4, 32'h46, 0, 0, 0, 0, 0, 6, 0);
        #1;
        chk("pre_rst_ready", {31'b0, lu_ready}, 32'h0);
        chk("pre_rst_stall", {31'b0, stall}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_write", {31'b0, write}, 32'h0);
        chk("mid_rst_ready", {31'b0, lu_ready}, 32'h1);
        chk("mid_rst_pending", pending, 32'h0);
        chk("mid_rst_stall", {31'b0, stall}, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_rst_write", {31'b0, write}, 32'h0);
        tick();
        chk("post_rst_write2", {31'b0, write}, 32'h0);

        mq.delete();
        mp = '0;
        mw = 1'b0;
        ma = '0;
        md = '0;

        for (int c = 0; c < 2000; c++) begin
            logic        pw, iss, lv, rdy;
            logic [4:0]  pa, ia, la, ra, rb;
            logic [31:0] pd, ld;
            logic        es;
            ent_t        e;
            pw  = ($urandom_range(0, 99) < 45);
            pa  = 5'($urandom_range(0, 7));
            pd  = $urandom;
            iss = ($urandom_range(0, 99) < 30);
            ia  = 5'($urandom_range(0, 7));
            lv  = ($urandom_range(0, 99) < 50);
            la  = 5'($urandom_range(0, 7));
            ld  = $urandom;
            ra  = 5'($urandom_range(0, 7));
            rb  = 5'($urandom_range(0, 7));
            drive(pw, pa, pd, iss, ia, lv, la, ld, ra, rb);
            #1;
            rdy = (mq.size() < 2);
            es  = ((ra != 0) && mp[ra]) || ((rb != 0) && mp[rb]);
            chk("rnd_ready", {31'b0, lu_ready}, {31'b0, rdy});
            chk("rnd_stall", {31'b0, stall}, {31'b0, es});
            if (pw && pa != 0) begin
                mw = 1'b1; ma = pa; md = pd;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                mw = 1'b1; ma = e.a; md = e.d;
                mp[e.a] = 1'b0;
            end else begin
                mw = 1'b0;
            end
            if (lv && rdy && la != 0) begin
                e.a = la;
                e.d = ld;
                mq.push_back(e);
            end
            if (iss && ia != 0) mp[ia] = 1'b1;
            mp[0] = 1'b0;
            tick();
            chk("rnd_write", {31'b0, write}, {31'b0, mw});
            chk("rnd_wrAddr", {27'b0, wrAddr}, {27'b0, ma});
            chk("rnd_wrData", wrData, md);
            chk("rnd_pending", pending, mp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter feeding the register file's single write port. Merges same-cycle pipeline results with out-of-order results from a long-latency unit (multiplier/divider, load miss path), buffering the latter in a 2-entry FIFO. Maintains a 32-bit pending-register scoreboard so decode can stall on reads of registers whose long-latency result has not yet been written.

## Interface
- No parameters; FIFO depth fixed at 2, data 32 bits, register address 5 bits.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pipe_write  in  1  pipeline writeback request this cycle
- pipe_wrAddr  in  5  pipeline destination register
- pipe_wrData  in  32  pipeline result
- lu_issue  in  1  long-latency op issued this cycle; marks destination pending
- lu_issueAddr  in  5  destination of issued long-latency op
- lu_valid  in  1  long-latency result available
- lu_wrAddr  in  5  long-latency result destination
- lu_wrData  in  32  long-latency result data
- lu_ready  out  1  FIFO can accept; transfer when lu_valid & lu_ready
- write  out  1  registered write enable to register file
- wrAddr  out  5  registered write address
- wrData  out  32  registered write data
- rdAddrA  in  5  decode read address A
- rdAddrB  in  5  decode read address B
- stall  out  1  decode must hold: a read targets a pending register
- pending  out  32  scoreboard, bit i = x_i awaiting long-latency result

## Operation
- FIFO: 2 entries {addr, data}, count 0..2, wrap-around read/write pointers. lu_ready = (count != 2), combinational.
- Enqueue on edge when lu_valid & lu_ready. lu_wrAddr == 0: entry dropped (not enqueued, lu_ready still handshakes).
- Per-cycle selection into output registers (priority):
  - pipe_write & pipe_wrAddr != 0: load {1, pipe_wrAddr, pipe_wrData}; FIFO holds.
  - else FIFO non-empty: load {1, head.addr, head.data}; dequeue.
  - else: write <= 0; wrAddr/wrData hold previous values.
- pipe_write with pipe_wrAddr == 0 treated as no request; FIFO may drain that cycle.
- Enqueue and dequeue same edge: count unchanged. Enqueue while count==2 impossible (lu_ready=0). An entry enqueued at edge N is eligible for selection from cycle N onward, i.e. loaded no earlier than edge N+1.
- Scoreboard:
  - set pending[lu_issueAddr] on edge when lu_issue & lu_issueAddr != 0.
  - clear pending[a] on edge when FIFO head with addr a is loaded into output registers.
  - set and clear of same bit same edge: set wins (newer op).
  - pending[0] always 0.
- stall = (rdAddrA != 0 & pending[rdAddrA]) | (rdAddrB != 0 & pending[rdAddrB]), combinational.
- Clearing at output-register load is safe: register file writes at the following edge and its internal write-to-read forwarding covers a read registered on that same edge.
- Upstream guarantees no pipeline write to a pending register (decode stall enforces it); not checked here.

## Timing
- Reset (async assert, sync-to-clk deassert by system): count=0, pointers=0, pending=0, write=0, wrAddr=0, wrData=0; hence lu_ready=1, stall=0 while reset high. Reset mid-drain discards FIFO contents and pending bits.
- Pipeline result at edge N -> write/wrAddr/wrData valid after edge N; register file captures at edge N+1.
- Long-latency result, idle pipeline: handshake edge N -> outputs after edge N+1; pending bit clears at edge N+1; stall drops in cycle after N+1.
- Continuous pipe_write with nonzero address starves FIFO; lu_ready falls after 2 accepted results.
- Throughput: one register write per cycle maximum.

## Test plan
- Reset: assert reset mid-cycle with FIFO holding 2 entries -> immediately write=0, lu_ready=1, pending=0, stall=0.
- Pipeline only: pipe_write=1, addr 5, data 0xDEADBEEF at edge N -> write=1, wrAddr=5, wrData=0xDEADBEEF after N; pipe_wrAddr=0 next cycle -> write=0.
- Scoreboard: lu_issue addr 7; rdAddrA=7 -> stall=1; lu_valid addr 7 data 0x12345678 with idle pipe -> wrAddr=7 after handshake+1 edge, pending[7]=0, stall=0 next cycle.
- Priority/backpressure: 3 consecutive lu_valid (addr 1,2,3) while pipe_write busy -> first two accepted, lu_ready=0 on third; release pipe -> writes 1,2 in order, then 3 accepted and written.
- Simultaneous set/clear: head addr 9 dequeued same edge lu_issue addr 9 -> pending[9] stays 1.
- x0 handling: lu_issue addr 0 and lu_valid addr 0 -> pending unchanged, no write, stall=0 for rdAddrA=0.
